score_bcd_converter: RTL and testbench



---
 rtl/score_bcd_converter.sv | 143 ++++++++++++++
 tb/tb_score_bcd_converter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/score_bcd_converter.sv
// Sequential binary-to-BCD (double-dabble) converter, one bit per clock, with a held result register.
// Optional leading-zero blanking is enabled with `define SCORE_BCD_BLANK_EN. DIGITS must satisfy 10^DIGITS > 2^WIDTH-1.
module score_bcd_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      i_score,
    input  logic                  i_start,
    output logic [4*DIGITS-1:0]   o_digits,
    output logic                  o_valid,
    output logic                  o_busy
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Handshake: i_start is honoured only when the state register is IDLE; o_valid is a
    // one-cycle pulse marking the first cycle o_digits holds a new result; o_busy = state != IDLE.

    // Replaces leading-zero digits above the most significant nonzero digit with 4'hF.
    // Digit 0 is always shown so a zero score still renders as "0".
    function automatic logic [BCD_W-1:0] format_digits(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] r;
`ifdef SCORE_BCD_BLANK_EN
        logic lead;
        lead = 1'b1;
`endif
        r = bcd;
`ifdef SCORE_BCD_BLANK_EN
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (lead && (bcd[4*d +: 4] == 4'd0)) begin
                r[4*d +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
`endif
        return r;
    endfunction

    localparam logic [BCD_W-1:0] DIGITS_RST = format_digits({BCD_W{1'b0}});

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   bin_sr;
    logic [BCD_W-1:0]   bcd_sr;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_next;
    logic [WIDTH-1:0]   bin_next;
    logic [BCD_W-1:0]   digits_fmt;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; starts outside IDLE are dropped, never queued
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_busy = (state_q != IDLE);

    // Per-nibble add-3 correction; each nibble is independent, no carry between them
    always_comb begin
        bcd_adj = bcd_sr;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_sr[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd_sr[4*d +: 4] + 4'd3;
            end
        end
    end

    assign {bcd_next, bin_next} = {bcd_adj, bin_sr} << 1;
    assign digits_fmt           = format_digits(bcd_sr);

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            bin_sr   <= '0;
            bcd_sr   <= '0;
            o_digits <= DIGITS_RST;
            o_valid  <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        bin_sr <= i_score;
                        bcd_sr <= '0;
                        cnt_q  <= '0;
                    end
                end
                SHIFT: begin
                    bin_sr <= bin_next;
                    bcd_sr <= bcd_next;
                    cnt_q  <= cnt_q + CNT_W'(1);
                end
                DONE: begin
                    o_digits <= digits_fmt;
                    o_valid  <= 1'b1;
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_bcd_converter.sv
// Bench for score_bcd_converter: scoreboard of expected digits and result cycles,
// protocol monitor on the falling edge, directed plus random conversions.
module tb_score_bcd_converter;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;
    localparam int BCD_W  = 4 * DIGITS;

    logic              clk;
    logic              rst;
    logic [WIDTH-1:0]  i_score;
    logic              i_start;
    logic [BCD_W-1:0]  o_digits;
    logic              o_valid;
    logic              o_busy;

    score_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_score  (i_score),
        .i_start  (i_start),
        .o_digits (o_digits),
        .o_valid  (o_valid),
        .o_busy   (o_busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [BCD_W-1:0] exp_q[$];
    int               exp_cyc_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    int               valid_cnt = 0;
    logic [BCD_W-1:0] prev_digits;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: decimal digits by division, then optional leading-zero blanking
    function automatic logic [BCD_W-1:0] model(input int unsigned v);
        logic [BCD_W-1:0] r;
        int unsigned      x;
        x = v;
        r = '0;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
`ifdef SCORE_BCD_BLANK_EN
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (r[4*d +: 4] != 4'd0) break;
            r[4*d +: 4] = 4'hF;
        end
`endif
        return r;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            prev_digits = o_digits;
        end else begin
            if (o_valid) begin
                valid_cnt++;
                check("busy_in_valid_cycle", 32'(o_busy), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    check("digits", 32'(o_digits), 32'(exp_q.pop_front()));
                    check("valid_cycle", cyc, exp_cyc_q.pop_front());
                end
            end else if (o_digits !== prev_digits) begin
                check("digits_stable", 32'(o_digits), 32'(prev_digits));
            end
            prev_digits = o_digits;
        end
    end

    // ---------------- driver tasks ----------------
    // One-cycle start pulse; returns just after the sample edge E0
    task automatic start_conv(input logic [WIDTH-1:0] v);
        @(posedge clk);
        #1;
        i_score = v;
        i_start = 1'b1;
        exp_q.push_back(model(v));
        exp_cyc_q.push_back(cyc + 1 + WIDTH + 1);
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            check("timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            exp_cyc_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    int busy_cnt;
    int v_before;
    logic [WIDTH-1:0] directed[4] = '{16'd65535, 16'd0, 16'd42, 16'd10000};

    initial begin
        rst     = 1'b1;
        i_score = '0;
        i_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_digits", 32'(o_digits), 32'(model(0)));
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Basic conversion with latency and busy-width checks
        start_conv(16'd12345);
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_busy) busy_cnt++;
        end
        check("busy_cycles", busy_cnt, WIDTH + 1);
        wait_done();

        foreach (directed[i]) begin
            start_conv(directed[i]);
            wait_done();
        end

        // Second start mid-conversion is dropped
        v_before = valid_cnt;
        start_conv(16'd100);
        repeat (4) @(posedge clk);
        #1;
        i_score = 16'd999;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        wait_done();
        repeat (20) @(posedge clk);
        check("ignored_start_valids", valid_cnt - v_before, 1);

        // Asynchronous reset mid-conversion aborts without o_valid
        start_conv(16'd200);
        repeat (8) @(posedge clk);
        #1;
        v_before = valid_cnt;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_digits", 32'(o_digits), 32'(model(0)));
        check("abort_valid", 32'(o_valid), 32'd0);
        exp_q.delete();
        exp_cyc_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (25) @(posedge clk);
        check("abort_no_valid", valid_cnt - v_before, 0);
        start_conv(16'd7);
        wait_done();

        // Start held high: back-to-back conversions every WIDTH+2 clocks
        for (int k = 1; k <= 3; k++) begin
            i_score = WIDTH'(k);
            i_start = 1'b1;
            exp_q.push_back(model(k));
            exp_cyc_q.push_back(cyc + 1 + WIDTH + 1);
            repeat (WIDTH + 2) @(posedge clk);
            #1;
        end
        i_start = 1'b0;
        wait_done();

        // Random scores
        for (int i = 0; i < 6; i++) begin
            start_conv(WIDTH'($urandom_range(0, 65535)));
            wait_done();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "global timeout");
    end

endmodule
